me_run_sequencer: RTL and testbench
===================================

Name: me_run_sequencer

Overview:
- Sequences the motion-estimation core (me_top) through a programmable number of back-to-back searches using the core's four-phase req/ack handshake.
- Replaces manual switch-driven req toggling at FPGA top level: one start pulse launches N runs.
- Captures each run's min_sad/min_mvec and tracks the best (lowest-SAD) result with its run index and per-run latency.
- Applies a watchdog timeout to every handshake phase; results feed the 7-segment display.

Parameters:
- SAD_W, 16, width of min_sad
- MVEC_W, 12, width of min_mvec
- RUN_W, 4, width of run count/index (max 15 runs)
- CYC_W, 20, width of per-run latency counter (saturating)
- TIMEOUT, 65535, cycles allowed in any single handshake wait before error

Ports:
- clk in 1: single clock (me_top clock domain)
- rst in 1: asynchronous, active-high reset
- start in 1: one-cycle pulse; launches a sequence when idle
- abort in 1: one-cycle pulse; terminates sequence cleanly
- num_runs in RUN_W: runs per sequence, sampled on accepted start
- me_req out 1: request to me_top
- me_ack in 1: acknowledge from me_top
- me_min_sad in SAD_W: core result, valid while me_ack=1
- me_min_mvec in MVEC_W: core result, valid while me_ack=1
- busy out 1: sequence in progress (any state except IDLE)
- done out 1: one-cycle pulse at normal completion
- err out 1: sticky timeout flag, cleared by next accepted start
- run_idx out RUN_W: index of run currently or last executed
- last_sad out SAD_W / last_mvec out MVEC_W: most recent captured result
- best_sad out SAD_W / best_mvec out MVEC_W / best_idx out RUN_W: best result of current sequence
- last_cycles out CYC_W: cycles from me_req rise to me_ack seen, last run

Behaviour:
- Reset values: all outputs 0, except best_sad all-ones. FSM enters IDLE.
- Reset mid-sequence: immediate return to IDLE; me_req drops asynchronously.
- FSM states: IDLE, REQ, CAPT, REL, NEXT, DRAIN.
- IDLE:
  - start=1 with abort=0: latch num_runs.
  - Clear err, run_idx=0, best_sad=all-ones, best_mvec=0, best_idx=0.
  - If num_runs=0: pulse done next cycle, remain IDLE, me_req never asserted. Otherwise go to REQ.
- REQ:
  - me_req=1; latency counter increments each cycle (saturates at all-ones).
  - me_ack=1: go to CAPT.
  - Watchdog reaches TIMEOUT: set err, go to DRAIN.
- CAPT (one cycle, me_req still 1):
  - Register me_min_sad/me_min_mvec into last_*; latency into last_cycles.
  - If me_min_sad < best_sad (strict): update best_* and best_idx=run_idx. Ties keep the earlier run.
  - Go to REL.
- REL:
  - me_req=0; wait for me_ack=0, then go to NEXT.
  - Watchdog timeout: set err, go to IDLE (no done).
- NEXT:
  - If run_idx = latched num_runs-1: pulse done, go to IDLE.
  - Else run_idx+1, reset latency counter, go to REQ.
  - Minimum gap between consecutive me_req rises: REQ→CAPT→REL→NEXT→REQ = 4 cycles when ack is immediate.
- DRAIN:
  - me_req=0; wait for me_ack=0 (watchdog applies), then go to IDLE.
  - No done; results already captured are retained.
- abort:
  - In REQ or CAPT: go to DRAIN; a capture in that same cycle is discarded.
  - In REL or NEXT: go to DRAIN.
  - In IDLE: ignored, and start in the same cycle is ignored (abort wins).
- start while busy: ignored.
- Watchdog counter resets on every state entry.
- me_req is a registered output, never combinational from me_ack.

Decomposition:
- Shared package me_pkg: FSM state enum, SAD_W/MVEC_W defaults, SAD_MAX constant (all-ones).
- One sub-module is natural: me_watchdog, a loadable down-counter with restart and expire outputs, reused for the REQ, REL and DRAIN waits.

Test Plan:
- Basic run: num_runs=3, core acks after 10 cycles with SADs 500, 200, 200 → best_sad=200, best_idx=1, last_cycles=10, done pulses once, me_req rises exactly 3 times.
- Zero runs: num_runs=0, start → done one cycle later, me_req stays 0, best_sad=16'hFFFF.
- Timeout: TIMEOUT=50, core never acks → err=1 after 50 cycles in REQ, me_req=0, no done, busy drops; a new start clears err.
- Abort: abort during REQ of run 1 of 4 with ack held high 5 extra cycles → me_req drops, FSM waits for ack low, returns to IDLE; run_idx=1, no done, run-0 results retained.
- Simultaneous events: start+abort in IDLE → nothing happens. start while busy → ignored, sequence completes unchanged.
- Reset mid-run: rst asserted in CAPT → me_req=0 immediately, all outputs return to reset values.

Source files
------------

// File: rtl/me_run_sequencer_pkg.sv
// Shared types and default widths for the motion-estimation run sequencer.
package me_run_sequencer_pkg;

   localparam int ME_SAD_W   = 16;
   localparam int ME_MVEC_W  = 12;
   localparam int ME_RUN_W   = 4;
   localparam int ME_CYC_W   = 20;
   localparam int ME_TIMEOUT = 65535;

   localparam logic [ME_SAD_W-1:0] SAD_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_CAPT,
      S_REL,
      S_NEXT,
      S_DRAIN
   } seq_state_e;

endpackage

// File: rtl/me_run_sequencer_watchdog.sv
// Handshake watchdog: restart_i marks the first cycle of a wait, expire_o rises in its TIMEOUT-th cycle.
// Zero latency on expire_o; no backpressure (TIMEOUT must be at least 2).
module me_run_sequencer_watchdog #(
   parameter int TIMEOUT = 65535
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   output logic expire_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The restart cycle itself counts as the first cycle of the wait.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = CNT_W'(TIMEOUT - 2);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = !restart_i && (cnt_q == '0);

endmodule

// File: rtl/me_run_sequencer.sv
// Runs me_top through N back-to-back four-phase req/ack searches and tracks the lowest-SAD result.
// me_req is registered; every handshake wait is bounded by the watchdog, abort drains cleanly.
module me_run_sequencer
   import me_run_sequencer_pkg::*;
#(
   parameter int SAD_W   = ME_SAD_W,
   parameter int MVEC_W  = ME_MVEC_W,
   parameter int RUN_W   = ME_RUN_W,
   parameter int CYC_W   = ME_CYC_W,
   parameter int TIMEOUT = ME_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [RUN_W-1:0]  num_runs_i,
   output logic              me_req_o,
   input  logic              me_ack_i,
   input  logic [SAD_W-1:0]  me_min_sad_i,
   input  logic [MVEC_W-1:0] me_min_mvec_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [RUN_W-1:0]  run_idx_o,
   output logic [SAD_W-1:0]  last_sad_o,
   output logic [MVEC_W-1:0] last_mvec_o,
   output logic [SAD_W-1:0]  best_sad_o,
   output logic [MVEC_W-1:0] best_mvec_o,
   output logic [RUN_W-1:0]  best_idx_o,
   output logic [CYC_W-1:0]  last_cycles_o
);

   seq_state_e        state_q;
   logic              me_req_q;
   logic              done_q;
   logic              err_q;
   logic [RUN_W-1:0]  run_idx_q;
   logic [RUN_W-1:0]  nruns_q;
   logic [SAD_W-1:0]  last_sad_q;
   logic [MVEC_W-1:0] last_mvec_q;
   logic [SAD_W-1:0]  best_sad_q;
   logic [MVEC_W-1:0] best_mvec_q;
   logic [RUN_W-1:0]  best_idx_q;
   logic [CYC_W-1:0]  lat_q;
   logic [CYC_W-1:0]  last_cycles_q;
   logic              wd_restart_q;
   logic              wd_expire;

   me_run_sequencer_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .restart_i (wd_restart_q),
      .expire_o  (wd_expire)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         me_req_q      <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         run_idx_q     <= '0;
         nruns_q       <= '0;
         last_sad_q    <= '0;
         last_mvec_q   <= '0;
         best_sad_q    <= '1;
         best_mvec_q   <= '0;
         best_idx_q    <= '0;
         lat_q         <= '0;
         last_cycles_q <= '0;
         wd_restart_q  <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         wd_restart_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i && !abort_i) begin
                  nruns_q     <= num_runs_i;
                  err_q       <= 1'b0;
                  run_idx_q   <= '0;
                  best_sad_q  <= '1;
                  best_mvec_q <= '0;
                  best_idx_q  <= '0;
                  if (num_runs_i == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q      <= S_REQ;
                     me_req_q     <= 1'b1;
                     lat_q        <= '0;
                     wd_restart_q <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (abort_i || (!me_ack_i && wd_expire)) begin
                  err_q        <= err_q | !abort_i;
                  state_q      <= S_DRAIN;
                  me_req_q     <= 1'b0;
                  wd_restart_q <= 1'b1;
               end else if (me_ack_i) begin
                  state_q <= S_CAPT;
               end else if (lat_q != '1) begin
                  lat_q <= lat_q + CYC_W'(1);
               end
            end
            S_CAPT: begin
               state_q      <= abort_i ? S_DRAIN : S_REL;
               me_req_q     <= 1'b0;
               wd_restart_q <= 1'b1;
               if (!abort_i) begin
                  last_sad_q    <= me_min_sad_i;
                  last_mvec_q   <= me_min_mvec_i;
                  last_cycles_q <= lat_q;
                  // Strict compare: on a tie the earlier run stays best.
                  if (me_min_sad_i < best_sad_q) begin
                     best_sad_q  <= me_min_sad_i;
                     best_mvec_q <= me_min_mvec_i;
                     best_idx_q  <= run_idx_q;
                  end
               end
            end
            S_REL: begin
               if (abort_i) begin
                  state_q      <= S_DRAIN;
                  wd_restart_q <= 1'b1;
               end else if (!me_ack_i) begin
                  state_q <= S_NEXT;
               end else if (wd_expire) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            S_NEXT: begin
               if (abort_i) begin
                  state_q      <= S_DRAIN;
                  wd_restart_q <= 1'b1;
               end else if (run_idx_q == nruns_q - RUN_W'(1)) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  run_idx_q    <= run_idx_q + RUN_W'(1);
                  lat_q        <= '0;
                  state_q      <= S_REQ;
                  me_req_q     <= 1'b1;
                  wd_restart_q <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (!me_ack_i) begin
                  state_q <= S_IDLE;
               end else if (wd_expire) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               me_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign me_req_o      = me_req_q;
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign run_idx_o     = run_idx_q;
   assign last_sad_o    = last_sad_q;
   assign last_mvec_o   = last_mvec_q;
   assign best_sad_o    = best_sad_q;
   assign best_mvec_o   = best_mvec_q;
   assign best_idx_o    = best_idx_q;
   assign last_cycles_o = last_cycles_q;

endmodule

// File: tb/tb_me_run_sequencer.sv
// Bench for me_run_sequencer: a behavioural me_top responder plus directed and randomised sequences.
module tb_me_run_sequencer;
   import me_run_sequencer_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [3:0]  num_runs;
   logic        me_req;
   logic        me_ack;
   logic [15:0] me_min_sad;
   logic [11:0] me_min_mvec;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  run_idx;
   logic [15:0] last_sad;
   logic [11:0] last_mvec;
   logic [15:0] best_sad;
   logic [11:0] best_mvec;
   logic [3:0]  best_idx;
   logic [19:0] last_cycles;

   me_run_sequencer #(
      .TIMEOUT (50)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .abort_i       (abort),
      .num_runs_i    (num_runs),
      .me_req_o      (me_req),
      .me_ack_i      (me_ack),
      .me_min_sad_i  (me_min_sad),
      .me_min_mvec_i (me_min_mvec),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err),
      .run_idx_o     (run_idx),
      .last_sad_o    (last_sad),
      .last_mvec_o   (last_mvec),
      .best_sad_o    (best_sad),
      .best_mvec_o   (best_mvec),
      .best_idx_o    (best_idx),
      .last_cycles_o (last_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stimulus tables, written only by the main sequence.
   logic [15:0] sad_tab  [16];
   logic [11:0] mvec_tab [16];
   int          delay_tab[16];
   int          base;
   int          hold;
   bit          never_ack;

   // Responder state, written only by the responder.
   int n_rise;
   int cyc;
   int rise_q[$];
   int n_done;

   int checks;
   int errors;

   // me_top model: ack delay_tab[k] cycles after req rises, hold ack 'hold' cycles after req drops.
   initial begin
      logic       prev_req;
      int         wait_cnt;
      int         rel_cnt;
      logic [3:0] k;
      me_ack = 1'b0; me_min_sad = '0; me_min_mvec = '0;
      n_rise = 0; cyc = 0; prev_req = 1'b0; wait_cnt = 0; rel_cnt = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (me_req && !prev_req) begin
            n_rise++;
            rise_q.push_back(cyc);
            wait_cnt = 0;
         end
         prev_req = me_req;
         if (me_req && !me_ack && !never_ack) begin
            k = 4'(n_rise - base - 1);
            if (wait_cnt >= delay_tab[k]) begin
               me_ack      = 1'b1;
               me_min_sad  = sad_tab[k];
               me_min_mvec = mvec_tab[k];
               rel_cnt     = 0;
            end else begin
               wait_cnt++;
            end
         end else if (!me_req && me_ack) begin
            if (rel_cnt >= hold) begin
               me_ack      = 1'b0;
               me_min_sad  = 16'($urandom);
               me_min_mvec = 12'($urandom);
            end else begin
               rel_cnt++;
            end
         end
      end
   end

   initial begin
      n_done = 0;
      forever begin
         @(negedge clk);
         if (done) n_done++;
      end
   end

   initial begin
      #600000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int n, input int dmax);
      for (int i = 0; i < 16; i++) begin
         sad_tab[i]   = 16'($urandom_range(0, 15));
         mvec_tab[i]  = 12'($urandom);
         delay_tab[i] = $urandom_range(0, dmax);
      end
      if (n > 16) $display("fill: table too short");
      base = n_rise;
   endtask

   task automatic pulse_start(input int n);
      @(posedge clk); #1;
      start = 1'b1; num_runs = 4'(n);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int i;
      for (i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk(tag, 32'(i < 1000), 32'd1);
   endtask

   task automatic wait_ack(input int nr, input string tag);
      int i;
      for (i = 0; i < 300; i++) begin
         @(posedge clk); #2;
         if ((n_rise - base) >= nr && me_ack) break;
      end
      chk(tag, 32'(i < 300), 32'd1);
   endtask

   // Expected results after ncap captured runs: best = first minimum, last = final capture.
   task automatic model_check(input string tag, input int ncap, input int ridx,
                              input int ndone, input int d0, input int nrise);
      logic [15:0] eb;
      logic [11:0] ebm;
      int          ei;
      eb = SAD_MAX; ebm = '0; ei = 0;
      for (int i = 0; i < ncap; i++) begin
         if (sad_tab[i] < eb) begin
            eb = sad_tab[i]; ebm = mvec_tab[i]; ei = i;
         end
      end
      chk({tag, ".best_sad"},    32'(best_sad),    32'(eb));
      chk({tag, ".best_mvec"},   32'(best_mvec),   32'(ebm));
      chk({tag, ".best_idx"},    32'(best_idx),    32'(ei));
      chk({tag, ".run_idx"},     32'(run_idx),     32'(ridx));
      chk({tag, ".last_sad"},    32'(last_sad),    32'(sad_tab[ncap-1]));
      chk({tag, ".last_mvec"},   32'(last_mvec),   32'(mvec_tab[ncap-1]));
      chk({tag, ".last_cycles"}, 32'(last_cycles), 32'(delay_tab[ncap-1]));
      chk({tag, ".done_count"},  32'(n_done - d0), 32'(ndone));
      chk({tag, ".req_rises"},   32'(n_rise - base), 32'(nrise));
   endtask

   initial begin
      int d0;
      int n;
      int cnt;
      checks = 0; errors = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; num_runs = '0;
      never_ack = 1'b0; hold = 0; base = 0;
      for (int i = 0; i < 16; i++) begin
         sad_tab[i] = '0; mvec_tab[i] = '0; delay_tab[i] = 0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.me_req", 32'(me_req), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.err", 32'(err), 32'd0);
      chk("rst.run_idx", 32'(run_idx), 32'd0);
      chk("rst.last_sad", 32'(last_sad), 32'd0);
      chk("rst.best_sad", 32'(best_sad), 32'(SAD_MAX));
      chk("rst.best_idx", 32'(best_idx), 32'd0);
      chk("rst.last_cycles", 32'(last_cycles), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Basic: SADs 500, 200, 200 with 10-cycle acks
      fill(3, 0);
      sad_tab[0] = 16'd500; sad_tab[1] = 16'd200; sad_tab[2] = 16'd200;
      for (int i = 0; i < 3; i++) delay_tab[i] = 10;
      d0 = n_done;
      pulse_start(3);
      wait_idle("basic.idle");
      model_check("basic", 3, 2, 1, d0, 3);
      chk("basic.best_sad_200", 32'(best_sad), 32'd200);
      chk("basic.best_idx_1", 32'(best_idx), 32'd1);

      // Immediate acks: req rises 4 cycles apart
      fill(4, 0);
      for (int i = 0; i < 4; i++) delay_tab[i] = 0;
      d0 = n_done;
      pulse_start(4);
      wait_idle("gap.idle");
      model_check("gap", 4, 3, 1, d0, 4);
      for (int i = 1; i < 4; i++)
         chk("gap.req_spacing", 32'(rise_q[base+i] - rise_q[base+i-1]), 32'd4);

      // Zero runs: done next cycle, no request
      base = n_rise; d0 = n_done;
      pulse_start(0);
      @(negedge clk);
      chk("zero.done", 32'(done), 32'd1);
      chk("zero.busy", 32'(busy), 32'd0);
      chk("zero.me_req", 32'(me_req), 32'd0);
      chk("zero.best_sad", 32'(best_sad), 32'(SAD_MAX));
      @(negedge clk);
      chk("zero.done_pulse", 32'(done), 32'd0);
      chk("zero.req_rises", 32'(n_rise - base), 32'd0);

      // Randomised sequences with ties and varied release delay
      repeat (6) begin
         n = $urandom_range(1, 8);
         fill(n, 12);
         hold = $urandom_range(0, 3);
         d0 = n_done;
         pulse_start(n);
         wait_idle("rand.idle");
         model_check("rand", n, n - 1, 1, d0, n);
      end
      hold = 0;

      // Timeout: no ack, err after 50 cycles in REQ
      fill(2, 0);
      never_ack = 1'b1;
      d0 = n_done;
      pulse_start(2);
      cnt = 0;
      for (int j = 0; j < 200; j++) begin
         @(negedge clk);
         if (err) break;
         cnt++;
      end
      chk("tmo.cycles", 32'(cnt), 32'd50);
      chk("tmo.me_req", 32'(me_req), 32'd0);
      wait_idle("tmo.idle");
      chk("tmo.err", 32'(err), 32'd1);
      chk("tmo.done_count", 32'(n_done - d0), 32'd0);
      never_ack = 1'b0;

      // start+abort together while idle: nothing happens, err stays set
      base = n_rise; d0 = n_done;
      @(posedge clk); #1 start = 1'b1; abort = 1'b1; num_runs = 4'd3;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("sa.busy", 32'(busy), 32'd0);
      chk("sa.err", 32'(err), 32'd1);
      chk("sa.req_rises", 32'(n_rise - base), 32'd0);

      // New start clears err
      fill(1, 5);
      d0 = n_done;
      pulse_start(1);
      @(negedge clk);
      chk("clr.err", 32'(err), 32'd0);
      wait_idle("clr.idle");
      model_check("clr", 1, 0, 1, d0, 1);

      // start while busy is ignored
      fill(3, 0);
      for (int i = 0; i < 3; i++) delay_tab[i] = 8;
      d0 = n_done;
      pulse_start(3);
      repeat (4) @(posedge clk);
      #1 start = 1'b1; num_runs = 4'd7;
      @(posedge clk); #1 start = 1'b0;
      wait_idle("sb.idle");
      model_check("sb", 3, 2, 1, d0, 3);

      // Abort in REQ of run 1 of 4 while ack rises; ack held 5 extra cycles
      fill(4, 0);
      for (int i = 0; i < 4; i++) delay_tab[i] = 3;
      hold = 5;
      d0 = n_done;
      pulse_start(4);
      wait_ack(2, "abtA.ack");
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abtA.me_req", 32'(me_req), 32'd0);
      repeat (2) @(negedge clk);
      chk("abtA.busy_drain", 32'(busy), 32'd1);
      wait_idle("abtA.idle");
      model_check("abtA", 1, 1, 0, d0, 2);
      chk("abtA.err", 32'(err), 32'd0);
      hold = 0;

      // Abort in CAPT of run 2 of 3: that capture is discarded
      fill(3, 0);
      for (int i = 0; i < 3; i++) delay_tab[i] = 2;
      d0 = n_done;
      pulse_start(3);
      wait_ack(3, "abtB.ack");
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      wait_idle("abtB.idle");
      model_check("abtB", 2, 2, 0, d0, 3);

      // Reset asserted in CAPT: me_req drops at once, outputs return to reset values
      fill(3, 0);
      for (int i = 0; i < 3; i++) delay_tab[i] = 4;
      pulse_start(3);
      wait_ack(2, "rstc.ack");
      @(posedge clk); #2;
      chk("rstc.me_req_capt", 32'(me_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstc.me_req", 32'(me_req), 32'd0);
      chk("rstc.busy", 32'(busy), 32'd0);
      chk("rstc.best_sad", 32'(best_sad), 32'(SAD_MAX));
      chk("rstc.last_sad", 32'(last_sad), 32'd0);
      chk("rstc.run_idx", 32'(run_idx), 32'd0);
      chk("rstc.last_cycles", 32'(last_cycles), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rstc.idle_after", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
